// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_pkg
// Description : Constants shared by the frame BRAM wrappers and the frame
//               sequencer: image geometry, BRAM address width, frame index
//               width and screen coordinate width, plus the frame-wrap helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vram_pkg;

    localparam int IMG_W       = 128;  // image width in image pixels
    localparam int IMG_H       = 128;  // image height in image pixels
    localparam int IMG_ADDR_W  = 14;   // {img_y[6:0], img_x[6:0]}
    localparam int FRAME_IDX_W = 4;    // up to 16 frame BRAMs
    localparam int SCREEN_W    = 10;   // VGA pixel coordinate width

    // Next animation frame, wrapping after the last BRAM of the bank.
    function automatic logic [FRAME_IDX_W-1:0] next_frame(
        input logic [FRAME_IDX_W-1:0] idx,
        input int                     num_frames
    );
        if (idx == FRAME_IDX_W'(num_frames - 1)) begin
            return '0;
        end
        return idx + FRAME_IDX_W'(1);
    endfunction

endpackage : vram_pkg
`default_nettype wire

// File: rtl/vram_frame_sequencer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : frame_scheduler
// Description : Chooses which animation frame is displayed. The index only
//               moves on a frame_start pulse, so a frame is never torn.
//               Auto-advance holds each frame HOLD_FRAMES display frames;
//               while paused, any number of step pulses collapse into a
//               single advance on the next frame_start.
// Ports       : clk, rst_n        - clock, async active-low reset
//               frame_start_i     - one-cycle pulse at start of vblank
//               play_i            - level, 1 = auto-advance
//               step_i            - one-cycle single-step request
//               frame_index_o     - currently displayed frame
// Revision    : 1.0 - initial release
// ============================================================================
module frame_scheduler
    import vram_pkg::*;
#(
    parameter int NUM_FRAMES  = 12,
    parameter int HOLD_FRAMES = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_start_i,
    input  logic                   play_i,
    input  logic                   step_i,
    output logic [FRAME_IDX_W-1:0] frame_index_o
);

    logic [7:0]             hold_cnt_q,     hold_cnt_d;
    logic                   step_pending_q, step_pending_d;
    logic [FRAME_IDX_W-1:0] frame_q,        frame_d;

    always_comb begin
        hold_cnt_d     = hold_cnt_q;
        step_pending_d = step_pending_q;
        frame_d        = frame_q;
        if (frame_start_i) begin
            if (play_i) begin
                if (hold_cnt_q == 8'(HOLD_FRAMES - 1)) begin
                    hold_cnt_d = '0;
                    frame_d    = next_frame(frame_q, NUM_FRAMES);
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end else if (step_pending_q || step_i) begin
                // A step arriving on the frame_start cycle itself counts too.
                frame_d        = next_frame(frame_q, NUM_FRAMES);
                step_pending_d = 1'b0;
            end
        end else if (step_i && !play_i) begin
            step_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q     <= '0;
            step_pending_q <= 1'b0;
            frame_q        <= '0;
        end else begin
            hold_cnt_q     <= hold_cnt_d;
            step_pending_q <= step_pending_d;
            frame_q        <= frame_d;
        end
    end

    assign frame_index_o = frame_q;

endmodule : frame_scheduler
`default_nettype wire

// File: rtl/vram_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vram_frame_sequencer
// Description : Maps VGA pixel coordinates into a scaled, positioned
//               128x128 image window, drives the shared frame-BRAM address
//               and a one-hot read enable, and muxes the selected BRAM bit
//               back as the pixel stream. Latency pixel_x/y -> pixel_out_o
//               is 3 clocks (address reg, BRAM read, output reg).
// Ports       : clk, rst_n            - clock, async active-low reset
//               pixel_x_i/pixel_y_i   - screen coordinates
//               video_on_i            - active display region
//               frame_start_i         - start-of-vblank pulse
//               play_i / step_i       - animation control
//               frame_pixel_i         - BRAM outputs, bit i = frame i
//               bram_address_o        - shared BRAM address
//               bram_read_enable_o    - one-hot (or zero) read enables
//               frame_index_o         - displayed frame
//               pixel_out_o           - pixel to the colour stage
//               pixel_valid_o         - pixel_out_o came from a BRAM
// Revision    : 1.0 - initial release
// ============================================================================
module vram_frame_sequencer
    import vram_pkg::*;
#(
    parameter int                  NUM_FRAMES  = 12,
    parameter int                  HOLD_FRAMES = 6,
    parameter int                  SCALE_SHIFT = 2,
    parameter logic [SCREEN_W-1:0] ORIGIN_X    = 10'd64,
    parameter logic [SCREEN_W-1:0] ORIGIN_Y    = 10'd0,
    parameter logic                BG_VALUE    = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SCREEN_W-1:0]    pixel_x_i,
    input  logic [SCREEN_W-1:0]    pixel_y_i,
    input  logic                   video_on_i,
    input  logic                   frame_start_i,
    input  logic                   play_i,
    input  logic                   step_i,
    input  logic [NUM_FRAMES-1:0]  frame_pixel_i,
    output logic [IMG_ADDR_W-1:0]  bram_address_o,
    output logic [NUM_FRAMES-1:0]  bram_read_enable_o,
    output logic [FRAME_IDX_W-1:0] frame_index_o,
    output logic                   pixel_out_o,
    output logic                   pixel_valid_o
);

    logic [FRAME_IDX_W-1:0] frame_index;

    frame_scheduler #(
        .NUM_FRAMES  (NUM_FRAMES),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_frame_scheduler (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start_i (frame_start_i),
        .play_i        (play_i),
        .step_i        (step_i),
        .frame_index_o (frame_index)
    );

    // ---------------- stage 0: window mapping ----------------
    logic [SCREEN_W-1:0] dx, dy, dx_s, dy_s;
    logic                in_window;

    assign dx   = pixel_x_i - ORIGIN_X;
    assign dy   = pixel_y_i - ORIGIN_Y;
    assign dx_s = dx >> SCALE_SHIFT;
    assign dy_s = dy >> SCALE_SHIFT;

    // The >= tests reject left/above the origin, where dx/dy wrap to large values.
    assign in_window = video_on_i
                    && (pixel_x_i >= ORIGIN_X) && (pixel_y_i >= ORIGIN_Y)
                    && (dx_s < SCREEN_W'(IMG_W)) && (dy_s < SCREEN_W'(IMG_H));

    // ---------------- pipeline registers ----------------
    logic [IMG_ADDR_W-1:0]  addr_q,  addr_d;
    logic [NUM_FRAMES-1:0]  ren_q,   ren_d;
    logic [FRAME_IDX_W-1:0] sel1_q;
    logic                   v1_q, pix2_q, v2_q, pix3_q, v3_q;
    logic                   pix_sel;

    // Address holds outside the window so the BRAM bus stays quiet.
    assign addr_d = in_window ? {dy_s[6:0], dx_s[6:0]} : addr_q;
    assign ren_d  = in_window ? (NUM_FRAMES'(1) << frame_index) : '0;

    // Mux uses the frame captured with the pixel, not the live index, so
    // pixels in flight across a frame change finish on their own frame.
    always_comb begin
        pix_sel = BG_VALUE;
        for (int i = 0; i < NUM_FRAMES; i++) begin
            if (sel1_q == FRAME_IDX_W'(i)) begin
                pix_sel = frame_pixel_i[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            ren_q  <= '0;
            sel1_q <= '0;
            v1_q   <= 1'b0;
            pix2_q <= BG_VALUE;
            v2_q   <= 1'b0;
            pix3_q <= BG_VALUE;
            v3_q   <= 1'b0;
        end else begin
            addr_q <= addr_d;
            ren_q  <= ren_d;
            sel1_q <= frame_index;
            v1_q   <= in_window;
            pix2_q <= pix_sel;
            v2_q   <= v1_q;
            pix3_q <= v2_q ? pix2_q : BG_VALUE;
            v3_q   <= v2_q;
        end
    end

    assign bram_address_o     = addr_q;
    assign bram_read_enable_o = ren_q;
    assign frame_index_o      = frame_index;
    assign pixel_out_o        = pix3_q;
    assign pixel_valid_o      = v3_q;

endmodule : vram_frame_sequencer
`default_nettype wire

// File: tb/tb_vram_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_frame_sequencer
// Description : Directed self-checking bench for vram_frame_sequencer with
//               default parameters (12 frames, hold 6, scale 4x, origin
//               (64,0), background 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pixel_x, pixel_y;
    logic        video_on, frame_start, play, step;
    logic [11:0] frame_pixel;
    logic [13:0] bram_address;
    logic [11:0] bram_read_enable;
    logic [3:0]  frame_index;
    logic        pixel_out, pixel_valid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vram_frame_sequencer dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pixel_x_i          (pixel_x),
        .pixel_y_i          (pixel_y),
        .video_on_i         (video_on),
        .frame_start_i      (frame_start),
        .play_i             (play),
        .step_i             (step),
        .frame_pixel_i      (frame_pixel),
        .bram_address_o     (bram_address),
        .bram_read_enable_o (bram_read_enable),
        .frame_index_o      (frame_index),
        .pixel_out_o        (pixel_out),
        .pixel_valid_o      (pixel_valid)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then read 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic [9:0] x, input logic [9:0] y, input logic v);
        pixel_x  = x;
        pixel_y  = y;
        video_on = v;
    endtask

    task automatic pulse_fs(input logic st);
        frame_start = 1'b1;
        step        = st;
        tick();
        frame_start = 1'b0;
        step        = 1'b0;
        tick();
    endtask

    // Window vectors with hand-computed address / validity (frame 0).
    localparam int N = 12;
    logic [9:0]  vx [N];
    logic [9:0]  vy [N];
    logic        vv [N];
    logic [13:0] eaddr [N];
    logic        evld [N];
    logic [15:0] fp_pat;

    initial begin
        vx[0]=10'd64;  vy[0]=10'd0;   vv[0]=1; eaddr[0]=14'h0000; evld[0]=1;
        vx[1]=10'd65;  vy[1]=10'd0;   vv[1]=1; eaddr[1]=14'h0000; evld[1]=1;
        vx[2]=10'd66;  vy[2]=10'd0;   vv[2]=1; eaddr[2]=14'h0000; evld[2]=1;
        vx[3]=10'd67;  vy[3]=10'd0;   vv[3]=1; eaddr[3]=14'h0000; evld[3]=1;
        vx[4]=10'd68;  vy[4]=10'd0;   vv[4]=1; eaddr[4]=14'h0001; evld[4]=1;
        vx[5]=10'd575; vy[5]=10'd0;   vv[5]=1; eaddr[5]=14'h007F; evld[5]=1;
        vx[6]=10'd576; vy[6]=10'd0;   vv[6]=1; eaddr[6]=14'h007F; evld[6]=0;
        vx[7]=10'd100; vy[7]=10'd0;   vv[7]=0; eaddr[7]=14'h007F; evld[7]=0;
        vx[8]=10'd63;  vy[8]=10'd0;   vv[8]=1; eaddr[8]=14'h007F; evld[8]=0;
        vx[9]=10'd64;  vy[9]=10'd511; vv[9]=1; eaddr[9]=14'h3F80; evld[9]=1;
        vx[10]=10'd71; vy[10]=10'd512; vv[10]=1; eaddr[10]=14'h3F80; evld[10]=0;
        vx[11]=10'd71; vy[11]=10'd5;  vv[11]=1; eaddr[11]=14'h0081; evld[11]=1;
        fp_pat = 16'b1011_0010_1101_0110;
    end

    initial begin
        logic b;
        rst_n = 1'b0;
        set_pix(10'd0, 10'd0, 1'b0);
        frame_start = 0; play = 0; step = 0; frame_pixel = '0;
        tick(); tick();

        // ---- reset state ----
        check_val("rst_addr",  32'(bram_address), 32'h0);
        check_val("rst_ren",   32'(bram_read_enable), 32'h0);
        check_val("rst_frame", 32'(frame_index), 32'h0);
        check_val("rst_pix",   32'(pixel_out), 32'h0);
        check_val("rst_vld",   32'(pixel_valid), 32'h0);
        rst_n = 1'b1;
        tick();

        // ---- window mapping and 3-cycle pipeline on frame 0 ----
        for (int k = 0; k < N + 2; k++) begin
            if (k < N) set_pix(vx[k], vy[k], vv[k]);
            else       set_pix(10'd0, 10'd0, 1'b0);
            b = fp_pat[k];
            frame_pixel = b ? 12'h001 : 12'hFFE;
            tick();
            if (k < N) begin
                check_val($sformatf("addr[%0d]", k), 32'(bram_address), 32'(eaddr[k]));
                check_val($sformatf("ren[%0d]", k), 32'(bram_read_enable), evld[k] ? 32'h001 : 32'h0);
            end
            if (k >= 2) begin
                check_val($sformatf("vld[%0d]", k-2), 32'(pixel_valid), 32'(evld[k-2]));
                check_val($sformatf("pix[%0d]", k-2), 32'(pixel_out),
                          evld[k-2] ? 32'(fp_pat[k-1]) : 32'h0);
            end
        end

        // ---- auto-advance: every 6 pulses, wrap at 72 ----
        play = 1'b1;
        for (int p = 1; p <= 72; p++) begin
            pulse_fs(1'b0);
            check_val($sformatf("play_idx[%0d]", p), 32'(frame_index), 32'((p / 6) % 12));
        end
        tick(); tick();
        check_val("idle_idx", 32'(frame_index), 32'h0);

        // ---- paused stepping ----
        play = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step = 1'b1; tick(); step = 1'b0; tick();
        end
        check_val("step_nofs", 32'(frame_index), 32'h0);
        pulse_fs(1'b0);
        check_val("step3_fs", 32'(frame_index), 32'h1);
        pulse_fs(1'b0);
        check_val("step_once", 32'(frame_index), 32'h1);
        pulse_fs(1'b1);
        check_val("step_coinc", 32'(frame_index), 32'h2);
        play = 1'b1;
        step = 1'b1; tick(); step = 1'b0; tick();
        play = 1'b0;
        pulse_fs(1'b0);
        check_val("step_play_ign", 32'(frame_index), 32'h2);

        // ---- pause freezes hold count, resume continues it ----
        play = 1'b1;
        for (int p = 0; p < 5; p++) pulse_fs(1'b0);
        check_val("hold5_idx", 32'(frame_index), 32'h2);
        play = 1'b0;
        pulse_fs(1'b0); pulse_fs(1'b0);
        check_val("pause_idx", 32'(frame_index), 32'h2);
        play = 1'b1;
        pulse_fs(1'b0);
        check_val("resume_idx", 32'(frame_index), 32'h3);

        // ---- frame change mid-stream: frame 3 -> 4 ----
        play = 1'b0;
        frame_pixel = 12'h008;   // frame 3 bit = 1, frame 4 bit = 0
        set_pix(10'd64, 10'd0, 1'b1);
        frame_start = 1'b1; step = 1'b1;
        tick();
        frame_start = 1'b0; step = 1'b0;
        check_val("mid_ren_old", 32'(bram_read_enable), 32'h008);
        check_val("mid_idx", 32'(frame_index), 32'h4);
        set_pix(10'd65, 10'd0, 1'b1);
        tick();
        check_val("mid_ren_new", 32'(bram_read_enable), 32'h010);
        set_pix(10'd0, 10'd0, 1'b0);
        tick();
        check_val("mid_pix_old", 32'(pixel_out), 32'h1);
        tick();
        check_val("mid_pix_new", 32'(pixel_out), 32'h0);
        check_val("mid_vld_new", 32'(pixel_valid), 32'h1);

        // ---- reset mid-line at frame 5 with a full pipeline ----
        pulse_fs(1'b1);
        check_val("pre_rst_idx", 32'(frame_index), 32'h5);
        frame_pixel = 12'hFFF;
        for (int k = 0; k < 4; k++) begin
            set_pix(10'(72 + 4 * k), 10'd8, 1'b1);
            step = (k == 0);
            tick();
        end
        step = 1'b0;
        check_val("pre_rst_pix", 32'(pixel_out), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mrst_addr",  32'(bram_address), 32'h0);
        check_val("mrst_ren",   32'(bram_read_enable), 32'h0);
        check_val("mrst_frame", 32'(frame_index), 32'h0);
        check_val("mrst_pix",   32'(pixel_out), 32'h0);
        check_val("mrst_vld",   32'(pixel_valid), 32'h0);
        set_pix(10'd0, 10'd0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        pulse_fs(1'b0);
        check_val("no_pending", 32'(frame_index), 32'h0);
        set_pix(10'd64, 10'd4, 1'b1);
        tick();
        set_pix(10'd0, 10'd0, 1'b0);
        check_val("post_rst_addr", 32'(bram_address), 32'h0080);
        check_val("post_vld0", 32'(pixel_valid), 32'h0);
        tick();
        check_val("post_vld1", 32'(pixel_valid), 32'h0);
        tick();
        check_val("post_vld2", 32'(pixel_valid), 32'h1);
        check_val("post_pix2", 32'(pixel_out), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_vram_frame_sequencer
`default_nettype wire
